// File: rtl/ifu_pkg.sv
// ifu_pkg: shared definitions for the instruction fetch unit.
// Holds the default reset PC, the fetch FSM state encoding and a PC alignment helper.
package ifu_pkg;

  localparam logic [31:0] IFU_RESET_PC = 32'h80000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } ifu_state_t;

  // Clear the byte-offset bits so a PC always names a whole instruction word.
  function automatic logic [31:0] ifu_align(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: small fetch buffer of {pc, inst} entries.
// Push and pop may fire on the same edge, even when full; flush empties it in one cycle.
// The head entry reads as zero while the buffer is empty.
module ifu_fifo #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_push,
  input  logic [63:0] i_data,
  input  logic        i_pop,
  input  logic        i_flush,
  output logic [63:0] o_data,
  output logic        o_full,
  output logic        o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   ONE_COUNT  = (AW + 1)'(1);
  localparam logic [AW-1:0] ONE_PTR    = AW'(1);

  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW:0]   r_count;
  logic          w_doPush;
  logic          w_doPop;

  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == FULL_COUNT);
  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!o_full || w_doPop);
  assign o_data   = o_empty ? 64'd0 : r_mem[r_rdPtr];

  // Pointer and occupancy bookkeeping; flush and reset both return to empty.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + ONE_PTR;
      if (w_doPop)  r_rdPtr <= r_rdPtr + ONE_PTR;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + ONE_COUNT;
        2'b01:   r_count <= r_count - ONE_COUNT;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; a write is suppressed on the edge the buffer is being emptied.
  always_ff @(posedge clk) begin
    if (w_doPush && !rst && !i_flush) r_mem[r_wrPtr] <= i_data;
  end

endmodule

// File: rtl/ifu.sv
// ifu: instruction fetch unit with one outstanding memory read and a small fetch buffer.
// Optional feature macro: IFU_MISALIGN_CHECK_EN -- a misaligned redirect sets a sticky
// err flag and halts fetching until reset; without it the target is word-aligned and err is 0.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        err
);

  ifu_state_t  r_state;
  ifu_state_t  w_nextState;
  logic [31:0] r_fetchPc;
  logic [31:0] w_redirPc;
  logic [63:0] w_headEntry;
  logic        w_full;
  logic        w_empty;
  logic        w_reqFire;
  logic        w_respPush;
  logic        w_pop;
  logic        w_respOwed;
  logic        w_errState;

  assign w_redirPc = ifu_align(redirect_pc);

`ifdef IFU_MISALIGN_CHECK_EN
  logic r_err;

  // Sticky error on any redirect whose target is not word aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      r_err <= 1'b1;
    end
  end

  assign w_errState = r_err;
`else
  logic w_unusedPcLow;
  assign w_unusedPcLow = ^redirect_pc[1:0];
  assign w_errState    = 1'b0;
`endif

  assign err = w_errState;

  // A request is withheld on a redirect cycle so an accepted read never races the new PC.
  assign mem_req_valid = (r_state == IDLE) && !w_full && !w_errState && !redirect_valid && !rst;
  assign mem_req_addr  = r_fetchPc;
  assign w_reqFire     = mem_req_valid && mem_req_ready;
  assign w_respPush    = (r_state == WAIT) && mem_resp_valid && !redirect_valid && !rst;
  assign w_respOwed    = ((r_state == WAIT) || (r_state == DROP)) && !mem_resp_valid;

  assign out_valid = !w_empty && !rst;
  assign w_pop     = out_valid && out_ready && !redirect_valid;
  assign out_pc    = w_headEntry[63:32];
  assign out_inst  = w_headEntry[31:0];

  ifu_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_respPush),
    .i_data  ({ifu_align(r_fetchPc - 32'd4), mem_resp_data}),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_data  (w_headEntry),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Next-state logic; a redirect with a read still owed must swallow that stale response.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:       if (w_reqFire) w_nextState = WAIT;
      WAIT, DROP: if (mem_resp_valid) w_nextState = IDLE;
      default:    w_nextState = IDLE;
    endcase
    if (redirect_valid) begin
      w_nextState = w_respOwed ? DROP : IDLE;
    end
  end

  // State register; reset still drops a response owed to a pre-reset request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= w_respOwed ? DROP : IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Fetch PC: reset value, redirect target, or advance by one word per accepted request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetchPc <= RESET_PC;
    end else if (redirect_valid) begin
      r_fetchPc <= w_redirPc;
    end else if (w_reqFire) begin
      r_fetchPc <= r_fetchPc + 32'd4;
    end
  end

endmodule

// File: tb/tb_ifu.sv
// tb_ifu: self-checking bench for the instruction fetch unit.
// Directed cycle table and hand sequences, then randomized traffic against a queue model.
module tb_ifu;

  localparam int          DEPTH = 2;
  localparam logic [31:0] P0    = 32'h80000000;
  localparam logic [31:0] PR    = 32'h80001000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = 32'd0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        err;

  int checks = 0;
  int errors = 0;

  ifu #(
    .RESET_PC (32'h80000000),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .err            (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        dv;
    logic [31:0] dp;
    logic        orr;
    logic        expReqV;
    logic [31:0] expAddr;
    logic        expOutV;
    logic [31:0] expPc;
    logic [31:0] expInst;
  } vec_t;

  vec_t vecs [17];

  // Instruction word the memory returns for a given address.
  function automatic logic [31:0] instFor(input logic [31:0] pc);
    return (pc * 32'd2654435761) ^ 32'h00000013;
  endfunction

  function automatic vec_t mkVec(input logic rdy, input logic rv, input logic [31:0] rd,
                                 input logic dv, input logic [31:0] dp, input logic orr,
                                 input logic expReqV, input logic [31:0] expAddr,
                                 input logic expOutV, input logic [31:0] expPc);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rd = rd; v.dv = dv; v.dp = dp; v.orr = orr;
    v.expReqV = expReqV; v.expAddr = expAddr; v.expOutV = expOutV;
    v.expPc = expOutV ? expPc : 32'd0;
    v.expInst = expOutV ? instFor(expPc) : 32'd0;
    return v;
  endfunction

  // Drive one cycle's inputs just after the falling edge, then let outputs settle.
  task automatic applyStimulus(input logic r, input logic rdy, input logic rv, input logic [31:0] rd,
                               input logic dv, input logic [31:0] dp, input logic orr);
    @(negedge clk);
    rst = r; mem_req_ready = rdy; mem_resp_valid = rv; mem_resp_data = rd;
    redirect_valid = dv; redirect_pc = dp; out_ready = orr;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model state for the randomized phase.
  logic [31:0] mQ [$];
  logic [31:0] mFetch;
  logic        mPending;
  logic        mStale;
  logic [31:0] mAddr;
  int          mLat;

  initial begin
    logic        rdy, orr, redir, resp, expReqValid, xfer, realResp;
    logic [31:0] tgt, rdata;

    vecs[0]  = mkVec(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, P0, 1'b0, 32'd0);
    vecs[1]  = mkVec(1'b1, 1'b1, instFor(P0), 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    vecs[2]  = mkVec(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, P0 + 32'd4, 1'b1, P0);
    vecs[3]  = mkVec(1'b1, 1'b1, instFor(P0 + 32'd4), 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1, P0);
    vecs[4]  = mkVec(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1, P0);
    vecs[5]  = mkVec(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1, P0);
    vecs[6]  = mkVec(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1, P0);
    vecs[7]  = mkVec(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, P0 + 32'd8, 1'b1, P0 + 32'd4);
    vecs[8]  = mkVec(1'b1, 1'b1, instFor(P0 + 32'd8), 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1, P0 + 32'd4);
    vecs[9]  = mkVec(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, P0 + 32'd12, 1'b1, P0 + 32'd8);
    vecs[10] = mkVec(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    vecs[11] = mkVec(1'b1, 1'b0, 32'd0, 1'b1, PR, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    vecs[12] = mkVec(1'b1, 1'b1, instFor(P0 + 32'd12), 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    vecs[13] = mkVec(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, PR, 1'b0, 32'd0);
    vecs[14] = mkVec(1'b1, 1'b1, instFor(PR), 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    vecs[15] = mkVec(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, PR + 32'd4, 1'b1, PR);
    vecs[16] = mkVec(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, PR + 32'd4, 1'b0, 32'd0);

    // Reset state.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    checkOutput("rstReqValid", mem_req_valid, 0);
    checkOutput("rstOutValid", out_valid, 0);
    checkOutput("rstErr", err, 0);

    // Reset fetch, backpressure, redirect while waiting.
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b0, vecs[i].rdy, vecs[i].rv, vecs[i].rd, vecs[i].dv, vecs[i].dp, vecs[i].orr);
      checkOutput($sformatf("vec%0d.reqValid", i), mem_req_valid, vecs[i].expReqV);
      if (vecs[i].expReqV) checkOutput($sformatf("vec%0d.reqAddr", i), mem_req_addr, vecs[i].expAddr);
      checkOutput($sformatf("vec%0d.outValid", i), out_valid, vecs[i].expOutV);
      checkOutput($sformatf("vec%0d.outPc", i), out_pc, vecs[i].expPc);
      checkOutput($sformatf("vec%0d.outInst", i), out_inst, vecs[i].expInst);
    end

    // Redirect, push and pop on the same edge.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("simA.reqAddr", mem_req_addr, PR + 32'd4);
    applyStimulus(1'b0, 1'b1, 1'b1, instFor(PR + 32'd4), 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("simC.reqAddr", mem_req_addr, PR + 32'd8);
    applyStimulus(1'b0, 1'b0, 1'b1, instFor(PR + 32'd8), 1'b1, 32'h90000000, 1'b1);
    checkOutput("simD.outValid", out_valid, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("simE.outValid", out_valid, 0);
    checkOutput("simE.outPc", out_pc, 0);
    checkOutput("simE.reqValid", mem_req_valid, 1);
    checkOutput("simE.reqAddr", mem_req_addr, 32'h90000000);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, instFor(32'h90000000), 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    checkOutput("simH.outPc", out_pc, 32'h90000000);
    checkOutput("simH.reqAddr", mem_req_addr, 32'h90000004);

    // PC wrap-around.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFFFFFC, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("wrap.reqAddr0", mem_req_addr, 32'hFFFFFFFC);
    applyStimulus(1'b0, 1'b0, 1'b1, instFor(32'hFFFFFFFC), 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    checkOutput("wrap.outPc", out_pc, 32'hFFFFFFFC);
    checkOutput("wrap.reqValid", mem_req_valid, 1);
    checkOutput("wrap.reqAddr1", mem_req_addr, 32'h00000000);

    // Misaligned redirect.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h80000002, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
`ifdef IFU_MISALIGN_CHECK_EN
      checkOutput("misalign.err", err, 1);
      checkOutput("misalign.reqValid", mem_req_valid, 0);
`else
      checkOutput("misalign.err", err, 0);
      checkOutput("misalign.reqValid", mem_req_valid, 1);
      checkOutput("misalign.reqAddr", mem_req_addr, 32'h80000000);
`endif
      checkOutput("misalign.outValid", out_valid, 0);
    end

    // Reset while a read is outstanding: its response must be discarded.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("rst2.err", err, 0);
    checkOutput("rst2.reqValid", mem_req_valid, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("rstWait.reqAddr", mem_req_addr, P0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h12345678, 1'b0);
    checkOutput("rstWait.reqValidInRst", mem_req_valid, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("rstWait.dropReqValid", mem_req_valid, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 32'd0, 1'b0);
    checkOutput("rstWait.staleReqValid", mem_req_valid, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("rstWait.outValid", out_valid, 0);
    checkOutput("rstWait.reqValid", mem_req_valid, 1);
    checkOutput("rstWait.reqAddr2", mem_req_addr, P0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, instFor(P0), 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("rstWait.outPc", out_pc, P0);
    checkOutput("rstWait.outInst", out_inst, instFor(P0));

    // Randomized traffic against the in-order stream model.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    mQ.delete();
    mFetch = P0; mPending = 1'b0; mStale = 1'b0; mAddr = 32'd0; mLat = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rdy   = ($urandom_range(0, 3) != 0);
      orr   = ($urandom_range(0, 2) != 0);
      redir = ($urandom_range(0, 19) == 0);
      tgt   = $urandom;
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFFFFF8 | (tgt & 32'h3);
`ifdef IFU_MISALIGN_CHECK_EN
      tgt[1:0] = 2'b00;
`endif
      realResp = mPending && (mLat == 0);
      resp  = realResp;
      rdata = realResp ? instFor(mAddr) : $urandom;
      if (!mPending && ($urandom_range(0, 7) == 0)) resp = 1'b1;
      applyStimulus(1'b0, rdy, resp, rdata, redir, tgt, orr);

      expReqValid = !mPending && (mQ.size() < DEPTH) && !redir;
      checkOutput("rnd.reqValid", mem_req_valid, expReqValid);
      if (expReqValid) checkOutput("rnd.reqAddr", mem_req_addr, mFetch);
      checkOutput("rnd.outValid", out_valid, mQ.size() > 0);
      checkOutput("rnd.outPc", out_pc, (mQ.size() > 0) ? mQ[0] : 32'd0);
      checkOutput("rnd.outInst", out_inst, (mQ.size() > 0) ? instFor(mQ[0]) : 32'd0);
      checkOutput("rnd.err", err, 0);

      xfer = expReqValid && rdy;
      if (redir) begin
        mQ.delete();
        mFetch = {tgt[31:2], 2'b00};
        if (mPending && !realResp) mStale = 1'b1;
      end else begin
        if (mQ.size() > 0 && orr) void'(mQ.pop_front());
        if (realResp && !mStale) mQ.push_back(mAddr);
      end
      if (realResp) begin
        mPending = 1'b0;
        mStale   = 1'b0;
      end else if (mPending) begin
        mLat--;
      end
      if (xfer) begin
        mPending = 1'b1;
        mStale   = 1'b0;
        mAddr    = mFetch;
        mLat     = $urandom_range(0, 2);
        mFetch   = mFetch + 32'd4;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
